// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Oversampling UART receiver. It takes one frame per start bit: a start bit,
//   DATA_BITS data bits sent LSB first, and one stop bit. The line is
//   synchronised and its falling edge starts a frame. The start bit is
//   confirmed at mid-bit, and every later bit is sampled one bit period after
//   the one before it.
//
// Parameters
//   DATA_BITS     data bits per frame
//   CLKS_PER_BIT  clk cycles per bit period (even, >= 4)
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   rx          serial line, asynchronous to clk, idles high
//   readAck     one-cycle pulse: consumer has taken rxData, clear status
//   rxData      last frame received with a good stop bit
//   rxValid     rxData holds unread data
//   frameError  sticky: a stop bit was sampled low
//   overrun     sticky: a good frame replaced unread data
//   busy        receiver is inside a frame (FSM not idle)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 readAck,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameError,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    // rx_meta/rx_s form the synchroniser; rx_prev is rx_s one cycle later.
    logic rx_meta;
    logic rx_s;
    logic rx_prev;

    logic stop_sample;
    logic stop_good;
    logic stop_bad;

    // ------------------------------------------------------------------
    // Input synchroniser. Its flops reset to the idle level, so a reset
    // release can never look like a falling edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Only a 1->0 transition starts a frame. A line that
                    // stays low (break) never satisfies this.
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;  // too short for a start bit
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        for (int unsigned i = 0; i < DATA_BITS; i++) begin
                            if (bit_idx == IDX_W'(i)) begin
                                shift_reg[i] <= rx_s;
                            end
                        end
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stop_sample = (state == STOP) && (cnt == BIT_LAST);
        stop_good   = stop_sample && rx_s;
        stop_bad    = stop_sample && !rx_s;
        busy        = (state != IDLE);
    end

    // ------------------------------------------------------------------
    // Consumer-visible status. A good-stop load takes priority over a
    // coincident readAck: the new word is kept valid and the ack counts
    // as consuming the old word, so overrun stays clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxData     <= '0;
            rxValid    <= 1'b0;
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end else if (stop_good) begin
            rxData  <= shift_reg;
            rxValid <= 1'b1;
            if (readAck) begin
                overrun    <= 1'b0;
                frameError <= 1'b0;
            end else if (rxValid) begin
                overrun <= 1'b1;
            end
        end else if (stop_bad) begin
            frameError <= 1'b1;
            if (readAck) begin
                rxValid <= 1'b0;
                overrun <= 1'b0;
            end
        end else if (readAck) begin
            rxValid    <= 1'b0;
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, sent LSB first.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 100: clk cycles per bit period; legal values are even and >= 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port readAck, input, 1 bit: one-cycle pulse; consumer has taken rxData and cleared status.
REQ-007 SHALL have port rxData, output, DATA_BITS: last frame received without error.
REQ-008 SHALL have port rxValid, output, 1 bit: rxData holds unread data.
REQ-009 SHALL have port frameError, output, 1 bit: sticky; a stop bit was sampled low.
REQ-010 SHALL have port overrun, output, 1 bit: sticky; a new frame overwrote unread data.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; the second-flop output (rxS) and its 1-cycle-delayed copy (rxPrev) are the only rx views used by the FSM.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, encoded as a 2-bit state register.
REQ-014 SHALL leave IDLE for START only on a falling edge (rxPrev=1, rxS=0), clearing the bit counter to 0; a line held low (break) SHALL NOT retrigger.
REQ-015 SHALL, in START, when the bit counter reaches CLKS_PER_BIT/2-1: go to DATA with counter=0 and bitIndex=0 if rxS=0; otherwise go to IDLE (glitch reject), with no change to any output.
REQ-016 SHALL, in DATA, when the counter reaches CLKS_PER_BIT-1: shift rxS into bit[bitIndex] of the shift register, clear the counter, and increment bitIndex; after DATA_BITS samples, go to STOP.
REQ-017 SHALL, in STOP, when the counter reaches CLKS_PER_BIT-1: sample rxS and return to IDLE.
REQ-018 SHALL, when the stop bit samples 1, load rxData from the shift register and set rxValid on the next clk edge.
REQ-018a SHALL, in the REQ-018 case with rxValid already 1 and no readAck in the same cycle, also set overrun (new data overwrites old).
REQ-019 SHALL, when the stop bit samples 0, set frameError and leave rxData and rxValid unchanged.
REQ-020 SHALL, on readAck, clear rxValid, frameError and overrun.
REQ-020a SHALL resolve readAck coinciding with a good-stop load as follows: the load wins; rxValid=1, rxData=new, overrun=0.
REQ-021 SHALL ignore readAck while rxValid=0 and frameError=0 (no effect).
REQ-022 SHALL size the counter at $clog2(CLKS_PER_BIT) bits and bitIndex at $clog2(DATA_BITS+1) bits; neither SHALL wrap during a frame.
REQ-023 SHALL, in steady operation, assert rxValid within 2 + CLKS_PER_BIT/2 + DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT + 2 clk cycles (+-1) after the start edge at the rx pin.
REQ-024 SHALL accept back-to-back frames (next start edge immediately after the stop bit) without losing data.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force state=IDLE, counter=0, bitIndex=0, shift register=0, rxData=0, rxValid=0, frameError=0, overrun=0, busy=0, and both synchronizer flops=1.
REQ-026 SHALL abandon any frame in progress when reset asserts mid-frame; after release, no output changes until a new falling edge completes a frame.
REQ-027 SHALL perform reset release synchronously with the first clk edge after reset_n rises.

Verification
REQ-028 Bench SHALL cover: CLKS_PER_BIT=16, send 0x48 (8N1) -> rxValid=1, rxData=0x48, frameError=0, overrun=0; readAck -> rxValid=0.
REQ-029 Bench SHALL cover: rx low pulse of 4 clk in IDLE -> busy rises and then returns to 0 with no output change (glitch reject).
REQ-030 Bench SHALL cover: send 0xA5 with stop bit=0 -> frameError=1, rxValid=0, rxData unchanged; line then held low 50 bit times -> no new frame.
REQ-031 Bench SHALL cover: send 0x11 then 0x22 back-to-back with no readAck -> rxData=0x22, rxValid=1, overrun=1; readAck clears both flags.
REQ-032 Bench SHALL cover: reset_n pulsed low during bit 3 of 0x5A -> all outputs 0 immediately; a following 0x3C is received correctly.
REQ-033 Bench SHALL cover: readAck in the same cycle as the stop-bit load of 0x77 with rxValid=1 -> rxValid=1, rxData=0x77, overrun=0.
